// File: rtl/fetch_unit_wide_pkg.sv
// Shared definitions for the wide fetch stage: widths, FSM states, queue entry.
package fetch_unit_wide_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // ISSUE: may send a request; WAIT: one request outstanding; DROP: discard next response
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // PC of lane 'lane' within a fetch group starting at 'base' (wraps mod 2^32)
  function automatic logic [ADDR_W-1:0] lane_pc(input logic [ADDR_W-1:0] base,
                                                input int unsigned       lane);
    return base + ADDR_W'(lane << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_wide_if.sv
// Fetch stage bus: instruction-memory request/response plus decode-side queue window.
interface fetch_unit_wide_if
  import fetch_unit_wide_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned FQ_DEPTH    = 8
);

  localparam int unsigned DEQ_W = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  logic                           STALL;
  logic                           Request_Alt_PC;
  logic [ADDR_W-1:0]              Alt_PC;
  logic [ADDR_W-1:0]              Instr_address_2IM;
  logic                           IM_Req_Valid;
  logic [FETCH_WIDTH*INSTR_W-1:0] Instr_fIM;
  logic                           Instr_fIM_IsValid;
  logic [DEQ_W-1:0]               Deq_Count;
  logic [CNT_W-1:0]               Out_Count;
  logic [FETCH_WIDTH-1:0]         Out_Valid;
  logic [FETCH_WIDTH*INSTR_W-1:0] Out_Instr;
  logic [FETCH_WIDTH*ADDR_W-1:0]  Out_PC;

  // Fetch unit side
  modport master (
    input  STALL, Request_Alt_PC, Alt_PC, Instr_fIM, Instr_fIM_IsValid, Deq_Count,
    output Instr_address_2IM, IM_Req_Valid, Out_Count, Out_Valid, Out_Instr, Out_PC
  );

  // Memory / decode / redirect side
  modport slave (
    output STALL, Request_Alt_PC, Alt_PC, Instr_fIM, Instr_fIM_IsValid, Deq_Count,
    input  Instr_address_2IM, IM_Req_Valid, Out_Count, Out_Valid, Out_Instr, Out_PC
  );

endinterface

// File: rtl/fetch_unit_wide_fetch_queue.sv
// Circular fetch queue: enqueues a full group per push, dequeues 0..FETCH_WIDTH per cycle,
// exposes the oldest FETCH_WIDTH entries as a window with unused lanes forced to zero.
module fetch_queue
  import fetch_unit_wide_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned FQ_DEPTH    = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           flush,
  input  logic                           enq_valid,
  input  fq_entry_t [FETCH_WIDTH-1:0]    enq_data,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] deq_count,
  output logic [$clog2(FQ_DEPTH+1)-1:0]  count,
  output logic [FETCH_WIDTH-1:0]         head_valid_c,
  output logic [FETCH_WIDTH*INSTR_W-1:0] head_instr_c,
  output logic [FETCH_WIDTH*ADDR_W-1:0]  head_pc_c
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  fq_entry_t        mem [FQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;

  assign count = count_q;

  // Group write; storage needs no reset because the window masks entries beyond count
  always_ff @(posedge CLK) begin
    if (enq_valid && !flush) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        mem[tail + PTR_W'(i)] <= enq_data[i];
      end
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head <= head + PTR_W'(deq_count);
      if (enq_valid) begin
        tail <= tail + PTR_W'(FETCH_WIDTH);
      end
      count_q <= count_q + (enq_valid ? CNT_W'(FETCH_WIDTH) : CNT_W'(0)) - CNT_W'(deq_count);
    end
  end

  // Head window, oldest entry in lane 0
  always_comb begin
    head_valid_c = '0;
    head_instr_c = '0;
    head_pc_c    = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        head_valid_c[i]                  = 1'b1;
        head_instr_c[i*INSTR_W +: INSTR_W] = mem[head + PTR_W'(i)].instr;
        head_pc_c[i*ADDR_W +: ADDR_W]      = mem[head + PTR_W'(i)].pc;
      end
    end
  end

endmodule

// File: rtl/fetch_unit_wide.sv
// Wide fetch stage: PC register, single-outstanding request FSM, redirect squash,
// and a decoupling fetch queue toward decode.
module fetch_unit_wide
  import fetch_unit_wide_pkg::*;
#(
  parameter int unsigned       FETCH_WIDTH = 2,
  parameter int unsigned       FQ_DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  fetch_unit_wide_if.master  bus
);

  localparam int unsigned DEQ_W       = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned CNT_W       = $clog2(FQ_DEPTH + 1);
  localparam int unsigned GROUP_BYTES = 4 * FETCH_WIDTH;

  fetch_state_e                   state;
  logic [ADDR_W-1:0]              pc;
  logic                           space_ok;
  logic                           issue;
  logic                           enq;
  logic [DEQ_W-1:0]               deq_eff;
  fq_entry_t [FETCH_WIDTH-1:0]    enq_data;
  logic [CNT_W-1:0]               q_count;
  logic [FETCH_WIDTH-1:0]         q_valid;
  logic [FETCH_WIDTH*INSTR_W-1:0] q_instr;
  logic [FETCH_WIDTH*ADDR_W-1:0]  q_pc;

  // A request reserves a whole group of queue space, so its response can never overflow
  assign space_ok = (CNT_W'(FQ_DEPTH) - q_count) >= CNT_W'(FETCH_WIDTH);
  assign issue    = (state == ST_ISSUE) && !bus.STALL && !bus.Request_Alt_PC && space_ok;
  assign enq      = (state == ST_WAIT) && bus.Instr_fIM_IsValid && !bus.Request_Alt_PC;
  assign deq_eff  = bus.Request_Alt_PC ? '0 : bus.Deq_Count;

  assign bus.IM_Req_Valid      = issue;
  assign bus.Instr_address_2IM = pc;
  assign bus.Out_Count         = q_count;
  assign bus.Out_Valid         = q_valid;
  assign bus.Out_Instr         = q_instr;
  assign bus.Out_PC            = q_pc;

  // Tag each response lane with its PC
  always_comb begin
    enq_data = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      enq_data[i].pc    = lane_pc(pc, i);
      enq_data[i].instr = bus.Instr_fIM[i*INSTR_W +: INSTR_W];
    end
  end

  // Request FSM and PC; a redirect overrides everything and squashes any in-flight group
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_ISSUE;
      pc    <= RESET_PC;
    end else if (bus.Request_Alt_PC) begin
      pc <= bus.Alt_PC;
      case (state)
        ST_WAIT: state <= bus.Instr_fIM_IsValid ? ST_ISSUE : ST_DROP;
        ST_DROP: state <= bus.Instr_fIM_IsValid ? ST_ISSUE : ST_DROP;
        default: state <= ST_ISSUE;
      endcase
    end else begin
      case (state)
        ST_ISSUE: begin
          if (issue) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.Instr_fIM_IsValid) begin
            pc    <= pc + ADDR_W'(GROUP_BYTES);
            state <= ST_ISSUE;
          end
        end
        ST_DROP: begin
          if (bus.Instr_fIM_IsValid) begin
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

  fetch_queue #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .FQ_DEPTH    (FQ_DEPTH)
  ) u_fetch_queue (
    .CLK          (CLK),
    .RESET        (RESET),
    .flush        (bus.Request_Alt_PC),
    .enq_valid    (enq),
    .enq_data     (enq_data),
    .deq_count    (deq_eff),
    .count        (q_count),
    .head_valid_c (q_valid),
    .head_instr_c (q_instr),
    .head_pc_c    (q_pc)
  );

endmodule

// File: tb/tb_fetch_unit_wide.sv
// Bench for fetch_unit_wide: directed vector table, reset/wrap sequences, random vs queue model.
module tb_fetch_unit_wide;
  import fetch_unit_wide_pkg::*;

  localparam int unsigned W0 = 2;
  localparam int unsigned D0 = 8;
  localparam int unsigned W1 = 4;
  localparam int unsigned D1 = 8;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  fetch_unit_wide_if #(.FETCH_WIDTH(W0), .FQ_DEPTH(D0)) b0 ();
  fetch_unit_wide_if #(.FETCH_WIDTH(W1), .FQ_DEPTH(D1)) b1 ();

  fetch_unit_wide #(.FETCH_WIDTH(W0), .FQ_DEPTH(D0)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b0.master)
  );

  fetch_unit_wide #(.FETCH_WIDTH(W1), .FQ_DEPTH(D1), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b1.master)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        stall;
    logic        alt;
    logic [31:0] alt_pc;
    logic        resp;
    logic [63:0] rdata;
    logic [1:0]  deq;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  cnt;
    logic        chk_lanes;
    logic [63:0] instr;
    logic [63:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic al, input logic [31:0] ap,
                              input logic rs, input logic [63:0] rd, input logic [1:0] dq,
                              input logic rq, input logic [31:0] ad, input logic [3:0] ct,
                              input logic cl, input logic [63:0] ei, input logic [63:0] ep);
    vec_t v;
    v.stall = st; v.alt = al; v.alt_pc = ap; v.resp = rs; v.rdata = rd; v.deq = dq;
    v.req = rq; v.addr = ad; v.cnt = ct; v.chk_lanes = cl; v.instr = ei; v.pc = ep;
    return v;
  endfunction

  function automatic logic [31:0] w(input int unsigned n);
    return 32'hC0DE_0000 + n;
  endfunction

  function automatic logic [1:0] valid_of(input logic [3:0] c);
    return (c >= 4'd2) ? 2'b11 : ((c == 4'd1) ? 2'b01 : 2'b00);
  endfunction

  // Behavioural model of the W0 instance: PC, outstanding/discard flags, queue of entries
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ment_t;
  ment_t       mq[$];
  logic [31:0] m_pc;
  bit          m_wait;
  bit          m_drop;

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'hBFC0_0000;
    m_wait = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_check(input int cyc);
    logic        e_req;
    logic [63:0] e_ins;
    logic [63:0] e_pc;
    logic [1:0]  e_val;
    e_req = !m_wait && !m_drop && !b0.STALL && !b0.Request_Alt_PC && ((D0 - mq.size()) >= W0);
    e_ins = '0; e_pc = '0; e_val = '0;
    for (int l = 0; l < int'(W0); l++) begin
      if (l < mq.size()) begin
        e_val[l]        = 1'b1;
        e_ins[l*32 +: 32] = mq[l].ins;
        e_pc[l*32 +: 32]  = mq[l].pc;
      end
    end
    chk($sformatf("rnd%0d req", cyc),   128'(b0.IM_Req_Valid),      128'(e_req));
    chk($sformatf("rnd%0d addr", cyc),  128'(b0.Instr_address_2IM), 128'(m_pc));
    chk($sformatf("rnd%0d count", cyc), 128'(b0.Out_Count),         128'(mq.size()));
    chk($sformatf("rnd%0d valid", cyc), 128'(b0.Out_Valid),         128'(e_val));
    chk($sformatf("rnd%0d instr", cyc), 128'(b0.Out_Instr),         128'(e_ins));
    chk($sformatf("rnd%0d pc", cyc),    128'(b0.Out_PC),            128'(e_pc));
  endtask

  task automatic model_step(input logic req, input logic st, input logic al, input logic [31:0] ap,
                            input logic rs, input logic [63:0] rd, input int dq);
    if (al) begin
      m_pc = ap;
      mq.delete();
      if (m_wait) begin
        m_wait = 1'b0;
        m_drop = !rs;
      end else if (m_drop && rs) begin
        m_drop = 1'b0;
      end
    end else begin
      repeat (dq) void'(mq.pop_front());
      if (m_wait && rs) begin
        for (int l = 0; l < int'(W0); l++) mq.push_back('{m_pc + 32'(4 * l), rd[l*32 +: 32]});
        m_pc   = m_pc + 32'(4 * W0);
        m_wait = 1'b0;
      end else if (m_drop && rs) begin
        m_drop = 1'b0;
      end else if (req) begin
        m_wait = 1'b1;
      end
    end
    if (st) begin end
  endtask

  vec_t tbl[28];

  initial begin
    tbl[0]  = mk(0,0,0,0,0,0, 1,32'hBFC00000,0,1,0,0);
    tbl[1]  = mk(0,0,0,1,{w(2),w(1)},0, 0,32'hBFC00000,0,1,0,0);
    tbl[2]  = mk(0,0,0,0,0,0, 1,32'hBFC00008,2,1,{w(2),w(1)},{32'hBFC00004,32'hBFC00000});
    tbl[3]  = mk(0,0,0,1,{w(4),w(3)},0, 0,32'hBFC00008,2,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0, 1,32'hBFC00010,4,0,0,0);
    tbl[5]  = mk(0,0,0,1,{w(6),w(5)},0, 0,32'hBFC00010,4,0,0,0);
    tbl[6]  = mk(0,0,0,0,0,0, 1,32'hBFC00018,6,0,0,0);
    tbl[7]  = mk(0,0,0,1,{w(8),w(7)},0, 0,32'hBFC00018,6,0,0,0);
    tbl[8]  = mk(0,0,0,0,0,2, 0,32'hBFC00020,8,1,{w(2),w(1)},{32'hBFC00004,32'hBFC00000});
    tbl[9]  = mk(0,0,0,0,0,0, 1,32'hBFC00020,6,1,{w(4),w(3)},{32'hBFC0000C,32'hBFC00008});
    tbl[10] = mk(0,1,32'h80001000,0,0,0, 0,32'hBFC00020,6,0,0,0);
    tbl[11] = mk(0,0,0,1,64'hDEAD_BEEF_DEAD_BEEF,0, 0,32'h80001000,0,1,0,0);
    tbl[12] = mk(0,0,0,0,0,0, 1,32'h80001000,0,1,0,0);
    tbl[13] = mk(0,1,32'h80002000,1,{w(10),w(9)},0, 0,32'h80001000,0,1,0,0);
    tbl[14] = mk(0,0,0,0,0,0, 1,32'h80002000,0,1,0,0);
    tbl[15] = mk(0,0,0,1,{w(12),w(11)},0, 0,32'h80002000,0,0,0,0);
    tbl[16] = mk(1,0,0,0,0,1, 0,32'h80002008,2,1,{w(12),w(11)},{32'h80002004,32'h80002000});
    tbl[17] = mk(0,0,0,0,0,0, 1,32'h80002008,1,1,{32'h0,w(12)},{32'h0,32'h80002004});
    tbl[18] = mk(0,0,0,0,0,1, 0,32'h80002008,1,0,0,0);
    tbl[19] = mk(0,0,0,1,{w(14),w(13)},0, 0,32'h80002008,0,1,0,0);
    tbl[20] = mk(1,0,0,1,{w(16),w(15)},0, 0,32'h80002010,2,1,{w(14),w(13)},{32'h8000200C,32'h80002008});
    tbl[21] = mk(0,0,0,0,0,0, 1,32'h80002010,2,1,{w(14),w(13)},{32'h8000200C,32'h80002008});
    tbl[22] = mk(0,0,0,1,{w(18),w(17)},0, 0,32'h80002010,2,0,0,0);
    tbl[23] = mk(0,1,32'h80003000,0,0,2, 0,32'h80002018,4,1,{w(14),w(13)},{32'h8000200C,32'h80002008});
    tbl[24] = mk(0,0,0,0,0,0, 1,32'h80003000,0,1,0,0);
    tbl[25] = mk(0,0,0,0,0,0, 0,32'h80003000,0,1,0,0);
    tbl[26] = mk(0,0,0,1,{w(20),w(19)},0, 0,32'h80003000,0,0,0,0);
    tbl[27] = mk(0,0,0,0,0,0, 1,32'h80003008,2,1,{w(20),w(19)},{32'h80003004,32'h80003000});

    RESET = 1'b1;
    b0.STALL = 0; b0.Request_Alt_PC = 0; b0.Alt_PC = 0;
    b0.Instr_fIM = '0; b0.Instr_fIM_IsValid = 0; b0.Deq_Count = '0;
    b1.STALL = 0; b1.Request_Alt_PC = 0; b1.Alt_PC = 0;
    b1.Instr_fIM = '0; b1.Instr_fIM_IsValid = 0; b1.Deq_Count = '0;

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst addr",  128'(b0.Instr_address_2IM), 128'(32'hBFC0_0000));
    chk("rst count", 128'(b0.Out_Count), 128'(0));
    chk("rst valid", 128'(b0.Out_Valid), 128'(0));
    chk("rst instr", 128'(b0.Out_Instr), 128'(0));
    chk("rst pc",    128'(b0.Out_PC),    128'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Directed table: first request, fill/backpressure, redirects, stall, ignored response
    for (int i = 0; i < 28; i++) begin
      b0.STALL             = tbl[i].stall;
      b0.Request_Alt_PC    = tbl[i].alt;
      b0.Alt_PC            = tbl[i].alt_pc;
      b0.Instr_fIM_IsValid = tbl[i].resp;
      b0.Instr_fIM         = tbl[i].rdata;
      b0.Deq_Count         = tbl[i].deq;
      @(negedge CLK);
      chk($sformatf("t%0d req", i),   128'(b0.IM_Req_Valid),      128'(tbl[i].req));
      chk($sformatf("t%0d addr", i),  128'(b0.Instr_address_2IM), 128'(tbl[i].addr));
      chk($sformatf("t%0d count", i), 128'(b0.Out_Count),         128'(tbl[i].cnt));
      chk($sformatf("t%0d valid", i), 128'(b0.Out_Valid),         128'(valid_of(tbl[i].cnt)));
      if (tbl[i].chk_lanes) begin
        chk($sformatf("t%0d instr", i), 128'(b0.Out_Instr), 128'(tbl[i].instr));
        chk($sformatf("t%0d pc", i),    128'(b0.Out_PC),    128'(tbl[i].pc));
      end
      @(posedge CLK); #1;
    end

    // Mid-operation reset takes effect without a clock edge
    b0.STALL = 0; b0.Request_Alt_PC = 0; b0.Instr_fIM_IsValid = 0; b0.Deq_Count = '0;
    RESET = 1'b1;
    #1;
    chk("midrst count", 128'(b0.Out_Count), 128'(0));
    chk("midrst addr",  128'(b0.Instr_address_2IM), 128'(32'hBFC0_0000));
    chk("midrst valid", 128'(b0.Out_Valid), 128'(0));
    chk("midrst instr", 128'(b0.Out_Instr), 128'(0));
    chk("midrst addr1", 128'(b1.Instr_address_2IM), 128'(32'hFFFF_FFF8));
    @(posedge CLK); #1;
    RESET = 1'b0;

    // W=4 group straddling the 2^32 wrap
    @(negedge CLK);
    chk("wrap req0",   128'(b1.IM_Req_Valid), 128'(1));
    chk("wrap addr0",  128'(b1.Instr_address_2IM), 128'(32'hFFFF_FFF8));
    @(posedge CLK); #1;
    b1.Instr_fIM_IsValid = 1'b1;
    b1.Instr_fIM = {w(104), w(103), w(102), w(101)};
    @(negedge CLK);
    chk("wrap req1",   128'(b1.IM_Req_Valid), 128'(0));
    @(posedge CLK); #1;
    b1.Instr_fIM_IsValid = 1'b0;
    @(negedge CLK);
    chk("wrap count",  128'(b1.Out_Count), 128'(4));
    chk("wrap valid",  128'(b1.Out_Valid), 128'(4'hF));
    chk("wrap pc",     128'(b1.Out_PC), {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
    chk("wrap instr",  128'(b1.Out_Instr), {w(104), w(103), w(102), w(101)});
    chk("wrap addr2",  128'(b1.Instr_address_2IM), 128'(32'h0000_0008));
    chk("wrap req2",   128'(b1.IM_Req_Valid), 128'(1));
    @(posedge CLK); #1;

    // Random traffic against the queue model
    RESET = 1'b1;
    b0.STALL = 0; b0.Request_Alt_PC = 0; b0.Instr_fIM_IsValid = 0; b0.Deq_Count = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        st, al, rs, rq;
      logic [31:0] ap;
      logic [63:0] rd;
      int          dq;
      int          hi;
      st = ($urandom % 5) == 0;
      al = ($urandom % 16) == 0;
      ap = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rs = ($urandom % 3) == 0;
      rd = {$urandom, $urandom};
      hi = (mq.size() < int'(W0)) ? mq.size() : int'(W0);
      dq = int'($urandom_range(0, hi));
      assert (dq <= mq.size()) else $error("Deq_Count exceeds occupancy");
      b0.STALL = st; b0.Request_Alt_PC = al; b0.Alt_PC = ap;
      b0.Instr_fIM_IsValid = rs; b0.Instr_fIM = rd; b0.Deq_Count = 2'(dq);
      @(negedge CLK);
      rq = !m_wait && !m_drop && !st && !al && ((D0 - mq.size()) >= W0);
      model_check(c);
      model_step(rq, st, al, ap, rs, rd, dq);
      @(posedge CLK); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
